controle_tentativas: RTL

//  Drives the guess comparator and consumes its verdict. On each confirmed guess it computes

---
 rtl/controle_tentativas.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/controle_tentativas.sv
// rtl/controle_tentativas.sv - guess sequencing, verdict registration and attempt counting
module controle_tentativas #(
    parameter int MAX_TENTATIVAS = 5,
    parameter int W_CONT         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        senha,
    input  logic [3:0]        tentativa,
    input  logic              confirmar,
    input  logic              reiniciar,
    output logic [3:0]        diff,
    output logic              sinal,
    input  logic              igual,
    input  logic              ate3,
    input  logic              errada,
    output logic              acertou,
    output logic              perto,
    output logic              errou,
    output logic              resultado_valido,
    output logic [W_CONT-1:0] tentativas_restantes,
    output logic              vitoria,
    output logic              derrota,
    output logic              erro_protocolo
);

    localparam logic [W_CONT-1:0] L_MAX = W_CONT'(MAX_TENTATIVAS);
    localparam logic [W_CONT-1:0] L_UM  = W_CONT'(1);

    typedef enum logic [1:0] {OCIOSO, AVALIA, VITORIA, DERROTA} estado_t;

    estado_t           r_estado;
    estado_t           w_prox;
    logic              r_conf_q;
    logic [4:0]        r_dif;
    logic              r_acertou;
    logic              r_perto;
    logic              r_errou;
    logic              r_valido;
    logic              r_erro;
    logic [W_CONT-1:0] r_rest;

    logic              w_evento;
    logic              w_um_quente;
    logic              w_acertou;
    logic              w_perto;
    logic              w_errou;
    logic              w_ultima;

    // Rising edge of the (already synchronised) confirm level; r_conf_q resets high
    // so a button held through reset does not register as a guess.
    assign w_evento = confirmar & ~r_conf_q;
    assign w_ultima = (r_rest == L_UM);

    // Decode the comparator verdict; anything other than exactly one flag is a wrong guess.
    always_comb begin
        w_um_quente = 1'b0;
        w_acertou   = 1'b0;
        w_perto     = 1'b0;
        w_errou     = 1'b1;
        case ({igual, ate3, errada})
            3'b100:  begin w_um_quente = 1'b1; w_acertou = 1'b1; w_errou = 1'b0; end
            3'b010:  begin w_um_quente = 1'b1; w_perto   = 1'b1; w_errou = 1'b0; end
            3'b001:  begin w_um_quente = 1'b1; end
            default: begin w_um_quente = 1'b0; end
        endcase
    end

    // Confirm-button history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_conf_q <= 1'b1;
        else        r_conf_q <= confirmar;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    // Next-state logic; new-game request overrides everything, game-over states are terminal.
    always_comb begin
        w_prox = r_estado;
        if (reiniciar) begin
            w_prox = OCIOSO;
        end else begin
            case (r_estado)
                OCIOSO:  if (w_evento) w_prox = AVALIA;
                AVALIA: begin
                    if (w_acertou)     w_prox = VITORIA;
                    else if (w_ultima) w_prox = DERROTA;
                    else               w_prox = OCIOSO;
                end
                default: w_prox = r_estado;
            endcase
        end
    end

    // Difference capture, verdict registration, attempt counter and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dif     <= '0;
            r_acertou <= 1'b0;
            r_perto   <= 1'b0;
            r_errou   <= 1'b0;
            r_valido  <= 1'b0;
            r_erro    <= 1'b0;
            r_rest    <= L_MAX;
        end else if (reiniciar) begin
            r_dif     <= '0;
            r_acertou <= 1'b0;
            r_perto   <= 1'b0;
            r_errou   <= 1'b0;
            r_valido  <= 1'b0;
            r_erro    <= 1'b0;
            r_rest    <= L_MAX;
        end else begin
            r_valido <= 1'b0;
            if (r_estado == OCIOSO && w_evento) begin
                r_dif <= {1'b0, tentativa} - {1'b0, senha};
            end
            if (r_estado == AVALIA) begin
                r_acertou <= w_acertou;
                r_perto   <= w_perto;
                r_errou   <= w_errou;
                r_valido  <= 1'b1;
                if (!w_um_quente) r_erro <= 1'b1;
                if (r_rest != '0) r_rest <= r_rest - L_UM;
            end
        end
    end

    assign diff                 = r_dif[3:0];
    assign sinal                = r_dif[4];
    assign acertou              = r_acertou;
    assign perto                = r_perto;
    assign errou                = r_errou;
    assign resultado_valido     = r_valido;
    assign tentativas_restantes = r_rest;
    assign vitoria              = (r_estado == VITORIA);
    assign derrota              = (r_estado == DERROTA);
    assign erro_protocolo       = r_erro;

endmodule
